// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared constants and helpers for the RAM port arbiter
//
// Purpose : default RAM geometry, owner encoding for the two requesters,
//           the response tag record and the two-way round-robin pick rule.
// Ports   : none (package).
package ram_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;

  // Owner encoding; also used as the bit index into 2-bit request vectors.
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  // Registered record of a read grant, used to steer the returning data.
  typedef struct packed {
    logic vld;
    logic own;
  } rsp_tag_t;

  // Winner of a two-way round robin. The result is meaningful only when
  // req is nonzero; on contention the requester that did not win last goes.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    logic pick;
    if (req == 2'b11) begin
      pick = ~last;
    end else if (req[OWN_B]) begin
      pick = OWN_B;
    end else begin
      pick = OWN_A;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rtl/ram_port_arbiter_rr_arb2.sv - two-input round-robin picker with last-granted register
//
// Purpose : picks one of two requesters each cycle; the pick is exposed
//           before gating so the caller can inspect the candidate (e.g. for
//           a hazard check) and then veto the grant through en_i.
// Ports   : clk, rst         - clock, synchronous active-high reset
//           req_i[1:0]       - request per owner (index = owner code)
//           en_i             - allow a grant this cycle
//           pick_vld_o       - at least one request present
//           pick_o           - candidate owner (valid with pick_vld_o)
//           gnt_o[1:0]       - one-hot grant, zero when en_i is low
module ram_port_arbiter_rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       pick_vld_o,
  output logic       pick_o,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    pick_vld_o = |req_i;
    pick_o     = rr_pick(req_i, last_q);
    gnt_o      = 2'b00;
    last_d     = last_q;
    // The pointer only moves on an actual grant, so a vetoed candidate
    // keeps its turn for the retry.
    if (en_i && pick_vld_o) begin
      gnt_o[pick_o] = 1'b1;
      last_d        = pick_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_B;  // A wins the first contention after reset
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares a 64x8 dual-port RAM between requesters A and B
//
// Purpose : routes writes to the RAM write port and reads to the RAM read
//           port, round-robin on each port, stalls a read whose address
//           matches the write granted in the same cycle, and returns read
//           data to its owner one cycle after the grant.
// Ports   : clk, rst                              - clock, sync active-high reset
//           a_req/a_wr/a_addr/a_wdata             - requester A operation
//           a_gnt                                 - A accepted (combinational)
//           a_rvalid/a_rdata                      - A read response
//           b_*                                   - same set for requester B
//           ram_we_en/ram_we_addr/ram_din         - RAM write port
//           ram_rd_en/ram_re_addr                 - RAM read port
//           ram_dout                              - RAM read data (1-cycle latency)
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic              ram_we_en,
  output logic [ADDR_W-1:0] ram_we_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_re_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [1:0] wr_req;
  logic [1:0] rd_req;
  logic       wr_pick_vld;
  logic       wr_pick;
  logic [1:0] wr_gnt;
  logic       rd_pick_vld;
  logic       rd_pick;
  logic [1:0] rd_gnt;
  logic       rd_en;
  logic       hazard;

  rsp_tag_t   tag_q;
  rsp_tag_t   tag_d;

  // Request classes, indexed by owner code.
  always_comb begin
    wr_req        = 2'b00;
    rd_req        = 2'b00;
    wr_req[OWN_A] = a_req & a_wr;
    wr_req[OWN_B] = b_req & b_wr;
    rd_req[OWN_A] = a_req & ~a_wr;
    rd_req[OWN_B] = b_req & ~b_wr;
  end

  ram_port_arbiter_rr_arb2 u_wr_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .req_i      (wr_req),
    .en_i       (~rst),
    .pick_vld_o (wr_pick_vld),
    .pick_o     (wr_pick),
    .gnt_o      (wr_gnt)
  );

  ram_port_arbiter_rr_arb2 u_rd_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .req_i      (rd_req),
    .en_i       (rd_en),
    .pick_vld_o (rd_pick_vld),
    .pick_o     (rd_pick),
    .gnt_o      (rd_gnt)
  );

  // Write port mux: the address/data follow the write candidate; they are
  // only meaningful while ram_we_en is high.
  always_comb begin
    ram_we_en   = |wr_gnt;
    ram_we_addr = (wr_pick == OWN_B) ? b_addr : a_addr;
    ram_din     = (wr_pick == OWN_B) ? b_wdata : a_wdata;
  end

  // Read port mux plus read-during-write hazard. The read candidate is
  // vetoed when it targets the address being written this cycle, so the
  // retry next cycle returns the freshly written value. The write side does
  // not depend on the read side, so there is no combinational loop.
  always_comb begin
    ram_re_addr = (rd_pick == OWN_B) ? b_addr : a_addr;
    hazard      = ram_we_en & rd_pick_vld & (ram_re_addr == ram_we_addr);
    rd_en       = ~rst & ~hazard;
    ram_rd_en   = |rd_gnt;
  end

  // A requester has only one pending op, so at most one of these is set.
  always_comb begin
    a_gnt = wr_gnt[OWN_A] | rd_gnt[OWN_A];
    b_gnt = wr_gnt[OWN_B] | rd_gnt[OWN_B];
  end

  // Response tag: remembers who owns the read the RAM is serving.
  always_comb begin
    tag_d.vld = ram_rd_en;
    tag_d.own = rd_pick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Steering of returned data; the rst term suppresses a response that was
  // in flight when reset arrived.
  always_comb begin
    a_rvalid = tag_q.vld & (tag_q.own == OWN_A) & ~rst;
    b_rvalid = tag_q.vld & (tag_q.own == OWN_B) & ~rst;
    a_rdata  = a_rvalid ? ram_dout : '0;
    b_rdata  = b_rvalid ? ram_dout : '0;
  end

endmodule
